// File: rtl/vendo_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vendo_in_pkg : shared constants, state type and priority helper for the     |
// |                vending-machine input conditioning front end.                |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package vendo_in_pkg;

   localparam int NUM_CH          = 4;

   // Channel index order is also the issue priority order (lowest wins).
   localparam int CH_P5           = 0;
   localparam int CH_P1           = 1;
   localparam int CH_SELA         = 2;
   localparam int CH_SELB         = 3;

   localparam int DB_CYCLES_DEF   = 16;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } issue_state_e;

   // One-hot pick of the lowest-index (highest-priority) set bit.
   function automatic logic [NUM_CH-1:0] prio_pick(input logic [NUM_CH-1:0] req);
      logic [NUM_CH-1:0] pick;
      pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage : vendo_in_pkg
`default_nettype wire

// File: rtl/vendo_db_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vendo_db_ch : one input channel - synchroniser, debounce counter, stable    |
// |               value and single-cycle stable-rise indication.               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vendo_db_ch
   import vendo_in_pkg::*;
#(
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic nrst,
   input  logic raw_i,
   output logic rise_o
);

   localparam int            CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   stable_q;
   logic                   stable_d;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   flip;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (nrst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // The flip happens on the DB_CYCLES-th consecutive differing cycle.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      flip     = 1'b0;
      if (synced != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            flip     = 1'b1;
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_o = flip & ~stable_q;

endmodule : vendo_db_ch
`default_nettype wire

// File: rtl/vendo_in_cond.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vendo_in_cond : debounced button/coin events handed to the vending FSM one  |
// |                 per divided-clock edge. VENDO_IN_DROP_EN: single action.    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module vendo_in_cond
   import vendo_in_pkg::*;
#(
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic nrst,
   input  logic div_clk,
   input  logic raw_sel_A,
   input  logic raw_sel_B,
   input  logic raw_p_1,
   input  logic raw_p_5,
   output logic sel_A,
   output logic sel_B,
   output logic p_1,
   output logic p_5,
   output logic busy
);

   logic [NUM_CH-1:0]      raw_vec;
   logic [NUM_CH-1:0]      rise;
   logic [NUM_CH-1:0]      grant;
   logic [NUM_CH-1:0]      pend_q;
   logic [NUM_CH-1:0]      pend_d;
   logic [NUM_CH-1:0]      out_q;
   logic [NUM_CH-1:0]      out_d;
   logic [SYNC_STAGES-1:0] div_sync_q;
   logic                   div_prev_q;
   logic                   div_rise;
   issue_state_e           state_q;
   issue_state_e           state_d;

   assign raw_vec[CH_P5]   = raw_p_5;
   assign raw_vec[CH_P1]   = raw_p_1;
   assign raw_vec[CH_SELA] = raw_sel_A;
   assign raw_vec[CH_SELB] = raw_sel_B;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      vendo_db_ch #(
         .DB_CYCLES   (DB_CYCLES),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_db (
         .clk    (clk),
         .nrst   (nrst),
         .raw_i  (raw_vec[gi]),
         .rise_o (rise[gi])
      );
   end

   assign div_rise = div_sync_q[SYNC_STAGES-1] & ~div_prev_q;

   always_ff @(posedge clk) begin
      if (nrst) begin
         div_sync_q <= '0;
         div_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         out_q      <= '0;
         pend_q     <= '0;
      end else begin
         div_sync_q <= {div_sync_q[SYNC_STAGES-2:0], div_clk};
         div_prev_q <= div_sync_q[SYNC_STAGES-1];
         state_q    <= state_d;
         out_q      <= out_d;
         pend_q     <= pend_d;
      end
   end

   // A div_rise seen while still idle (the issuing edge) is deliberately ignored.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      grant   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               grant   = prio_pick(pend_q);
               out_d   = grant;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (div_rise) begin
               out_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            out_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef VENDO_IN_DROP_EN
   logic [NUM_CH-1:0] accept;

   always_comb begin
      accept = (state_q == ST_ACTIVE) ? '0 : rise;
      pend_d = prio_pick((pend_q & ~grant) | accept);
   end
`else
   // A press on the channel being issued re-arms its pend bit for a second event.
   always_comb begin
      pend_d = (pend_q & ~grant) | rise;
   end
`endif

   assign p_5   = out_q[CH_P5];
   assign p_1   = out_q[CH_P1];
   assign sel_A = out_q[CH_SELA];
   assign sel_B = out_q[CH_SELB];
   assign busy  = (state_q == ST_ACTIVE);

endmodule : vendo_in_cond
`default_nettype wire

// File: tb/tb_vendo_in_cond.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vendo_in_cond : directed self-checking bench for vendo_in_cond.          |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_vendo_in_cond;

   logic clk       = 1'b0;
   logic nrst      = 1'b1;
   logic div_clk   = 1'b0;
   logic raw_sel_A = 1'b0;
   logic raw_sel_B = 1'b0;
   logic raw_p_1   = 1'b0;
   logic raw_p_5   = 1'b0;
   logic sel_A;
   logic sel_B;
   logic p_1;
   logic p_5;
   logic busy;

   int   tests   = 0;
   int   fails   = 0;
   int   ev_code = 0;
   int   ev_cnt  = 0;
   int   inv_err = 0;
   int   hi_len  = 0;
   bit   div_run = 1'b1;
   bit   chk_len = 1'b1;
   logic [3:0] prev_outs = '0;

   // Event codes: p_5=1, p_1=2, sel_A=3, sel_B=4, accumulated as octal digits.
`ifdef VENDO_IN_DROP_EN
   localparam int EXP_RST = 'o1,   EXP_RST_N = 1;
   localparam int EXP_SIM = 'o1,   EXP_SIM_N = 1;
   localparam int EXP_STK = 'o3,   EXP_STK_N = 1;
   localparam int EXP_RP  = 'o2,   EXP_RP_N  = 1;
`else
   localparam int EXP_RST = 'o1234, EXP_RST_N = 4;
   localparam int EXP_SIM = 'o124,  EXP_SIM_N = 3;
   localparam int EXP_STK = 'o312,  EXP_STK_N = 3;
   localparam int EXP_RP  = 'o22,   EXP_RP_N  = 2;
`endif

   vendo_in_cond #(
      .DB_CYCLES   (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .div_clk   (div_clk),
      .raw_sel_A (raw_sel_A),
      .raw_sel_B (raw_sel_B),
      .raw_p_1   (raw_p_1),
      .raw_p_5   (raw_p_5),
      .sel_A     (sel_A),
      .sel_B     (sel_B),
      .p_1       (p_1),
      .p_5       (p_5),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always begin
      #40;
      if (div_run) div_clk = ~div_clk;
   end

   // Event log plus one-hot / busy / one-div-period invariants.
   always @(negedge clk) begin : mon
      logic [3:0] outs;
      outs = {sel_B, sel_A, p_1, p_5};
      if ($countones(outs) > 1) inv_err++;
      if (busy !== (|outs)) inv_err++;
      for (int i = 0; i < 4; i++) begin
         if (outs[i] && !prev_outs[i]) begin
            ev_code = ev_code * 8 + i + 1;
            ev_cnt++;
         end
      end
      if (|outs) begin
         hi_len++;
      end else begin
         if ((|prev_outs) && chk_len && hi_len > 8) inv_err++;
         hi_len = 0;
      end
      prev_outs = outs;
   end

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_log(input string tag, input int exp_code, input int exp_n);
      @(posedge clk);
      check({tag, "_seq"}, ev_code, exp_code);
      check({tag, "_cnt"}, ev_cnt, exp_n);
      check({tag, "_inv"}, inv_err, 0);
      ev_code = 0;
      ev_cnt  = 0;
      inv_err = 0;
   endtask

   initial begin
      // Reset held with every raw input high.
      raw_sel_A = 1'b1;
      raw_sel_B = 1'b1;
      raw_p_1   = 1'b1;
      raw_p_5   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_idle", int'({sel_A, sel_B, p_1, p_5, busy}), 0);
      end
      nrst = 1'b0;
      @(posedge clk);
      ev_code = 0;
      ev_cnt  = 0;
      inv_err = 0;
      cycles(60);
      check_log("rst_high", EXP_RST, EXP_RST_N);
      @(negedge clk);
      raw_sel_A = 1'b0;
      raw_sel_B = 1'b0;
      raw_p_1   = 1'b0;
      raw_p_5   = 1'b0;
      cycles(20);
      check_log("release", 0, 0);

      // Three-cycle glitch is filtered.
      @(negedge clk) raw_p_1 = 1'b1;
      cycles(3);
      raw_p_1 = 1'b0;
      cycles(30);
      check_log("glitch", 0, 0);

      // Exactly DB_CYCLES high is accepted.
      @(negedge clk) raw_p_1 = 1'b1;
      cycles(4);
      raw_p_1 = 1'b0;
      cycles(40);
      check_log("db_edge", 'o2, 1);

      // Held button gives one event.
      @(negedge clk) raw_sel_A = 1'b1;
      cycles(20);
      raw_sel_A = 1'b0;
      cycles(30);
      check_log("single", 'o3, 1);

      // Simultaneous presses drain in priority order.
      @(negedge clk);
      raw_p_5   = 1'b1;
      raw_sel_B = 1'b1;
      raw_p_1   = 1'b1;
      cycles(20);
      raw_p_5   = 1'b0;
      raw_sel_B = 1'b0;
      raw_p_1   = 1'b0;
      cycles(50);
      check_log("simul", EXP_SIM, EXP_SIM_N);

      // div_clk stuck: sel_A held, later presses queue (p_5 twice merges).
      @(negedge clk);
      div_run = 1'b0;
      chk_len = 1'b0;
      cycles(5);
      raw_sel_A = 1'b1;
      cycles(20);
      check("stuck_issue", int'(sel_A), 1);
      raw_sel_A = 1'b0;
      raw_p_5   = 1'b1;
      raw_p_1   = 1'b1;
      cycles(6);
      raw_p_5 = 1'b0;
      raw_p_1 = 1'b0;
      cycles(6);
      raw_p_5 = 1'b1;
      cycles(6);
      raw_p_5 = 1'b0;
      cycles(10);
      check("stuck_hold", int'({sel_A, p_5, p_1, busy}), 'b1001);
      div_run = 1'b1;
      cycles(70);
      check_log("stuck", EXP_STK, EXP_STK_N);

      // Re-press of p_1 while its output is still active.
      @(negedge clk);
      div_run = 1'b0;
      cycles(5);
      raw_p_1 = 1'b1;
      cycles(6);
      raw_p_1 = 1'b0;
      cycles(6);
      raw_p_1 = 1'b1;
      cycles(6);
      raw_p_1 = 1'b0;
      cycles(10);
      check("repress_hold", int'(p_1), 1);
      div_run = 1'b1;
      cycles(50);
      check_log("repress", EXP_RP, EXP_RP_N);

      // Reset while sel_B active and p_5 pending.
      @(negedge clk);
      div_run = 1'b0;
      cycles(5);
      raw_sel_B = 1'b1;
      cycles(20);
      check("mid_selB", int'(sel_B), 1);
      raw_p_5 = 1'b1;
      cycles(6);
      raw_sel_B = 1'b0;
      raw_p_5   = 1'b0;
      cycles(10);
      nrst = 1'b1;
      @(negedge clk);
      check("mid_rst", int'({sel_A, sel_B, p_1, p_5, busy}), 0);
      nrst = 1'b0;
      @(posedge clk);
      ev_code = 0;
      ev_cnt  = 0;
      inv_err = 0;
      chk_len = 1'b1;
      @(negedge clk);
      div_run = 1'b1;
      cycles(60);
      check_log("mid_after", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_vendo_in_cond
`default_nettype wire
